// File: rtl/mem_depacketizer_if.sv
// Packet-in / result-out handshake bundle for mem_depacketizer.
//   pkt_valid/pkt_ready/pkt_data : packet stream from the adder packetizer
//   out_valid/out_ready          : decoded result stream to the memory write port
//   out_type/out_src/out_data    : fields of the head result
//   out_index                    : index of the head result within the run
// Modports: slave = the depacketizer, master = producer/consumer side.
interface mem_depacketizer_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned PWIDTH = 47,
  parameter int unsigned IDX_W  = 5
);
  logic              pkt_valid;
  logic              pkt_ready;
  logic [PWIDTH-1:0] pkt_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_type;
  logic [2:0]        out_src;
  logic [DWIDTH-1:0] out_data;
  logic [IDX_W-1:0]  out_index;

  modport slave (
    input  pkt_valid, pkt_data, out_ready,
    output pkt_ready, out_valid, out_type, out_src, out_data, out_index
  );

  modport master (
    output pkt_valid, pkt_data, out_ready,
    input  pkt_ready, out_valid, out_type, out_src, out_data, out_index
  );
endinterface

// File: rtl/mem_depacketizer.sv
// Memory-node receive end of the PE packet network. Accepts final partial-sum
// packets, buffers {type, src, data} in a DEPTH-entry FIFO and presents them with
// a running output index. Signals done (sticky) after NUM_OUT results.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous restart of the run (drop_cnt survives)
//   bus        : mem_depacketizer_if.slave (packet in, result out)
//   done       : NUM_OUT results delivered
//   drop_cnt   : saturating count of misaddressed packets
// Optional feature: define MEM_DEPKT_ADDR_CHECK_EN to discard packets whose
// destination field differs from MY_ADDR.
module mem_depacketizer #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned PWIDTH  = 47,
  parameter logic [2:0]  MY_ADDR = 3'b110,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_OUT = 16,
  parameter int unsigned IDX_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  mem_depacketizer_if.slave   bus,
  output logic                done,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     EntW    = 1 + 3 + DWIDTH;
  localparam logic [PtrW:0]   FullCnt = (PtrW+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_OUT - 1);

  typedef enum logic [0:0] {StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ready_en_q;
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EntW-1:0]  mem_q [DEPTH];
  logic [PtrW:0]    fill;
  logic             full, empty;
  logic             pkt_ready_w, hs_in, push, pop, addr_ok;
  logic [EntW-1:0]  wr_entry, head;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fill  = wr_ptr_q - rd_ptr_q;
  assign full  = (fill == FullCnt);
  assign empty = (fill == '0);

  // ready_en_q keeps pkt_ready low until the first edge after reset release.
  assign pkt_ready_w   = ready_en_q && (state_q == StRun) && !full;
  assign bus.pkt_ready = pkt_ready_w;
  assign bus.out_valid = !empty;
  assign done          = (state_q == StDone);
  assign bus.out_index = idx_q;

`ifdef MEM_DEPKT_ADDR_CHECK_EN
  assign addr_ok = (bus.pkt_data[45:43] == MY_ADDR);
`else
  assign addr_ok = 1'b1;
`endif

  // A handshake in a clear cycle is swallowed: clear wins over push and pop.
  assign hs_in = bus.pkt_valid && pkt_ready_w && !clear;
  assign push  = hs_in && addr_ok;
  assign pop   = !empty && bus.out_ready && !clear;

  assign wr_entry = {bus.pkt_data[46], bus.pkt_data[42:40], bus.pkt_data[DWIDTH-1:0]};
  assign head     = mem_q[rd_ptr_q[PtrW-1:0]];
  // Fields read as zero while empty so they match their reset values.
  assign {bus.out_type, bus.out_src, bus.out_data} = empty ? {EntW{1'b0}} : head;

  // Pad bits and (in the default build) the address are intentionally ignored.
  logic unused_pkt;
  assign unused_pkt = ^{bus.pkt_data, MY_ADDR};

  always_comb begin
    wr_ptr_d = clear ? '0 : wr_ptr_q + {{PtrW{1'b0}}, push};
    rd_ptr_d = clear ? '0 : rd_ptr_q + {{PtrW{1'b0}}, pop};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StRun: begin
        if (pop) begin
          if (idx_q == LastIdx) state_d = StDone;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      StDone: begin
        // Leftover entries drain without advancing the index.
      end
      default: state_d = StRun;
    endcase
    if (clear) begin
      state_d = StRun;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      idx_q      <= '0;
      ready_en_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_en_q <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= wr_entry;
  end

`ifdef MEM_DEPKT_ADDR_CHECK_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 8'd0;
    end else if (hs_in && !addr_ok && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mem_depacketizer.sv
// Self-checking bench for mem_depacketizer: queue-based reference model compared
// every negedge, plus directed scenarios with literal expectations.
module tb_mem_depacketizer;
  localparam int unsigned DW      = 8;
  localparam int unsigned PW      = 47;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NUM_OUT = 16;
  localparam int unsigned IDX_W   = 5;
  localparam logic [2:0]  MY_ADDR = 3'b110;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       done;
  logic [7:0] drop_cnt;

  mem_depacketizer_if #(.DWIDTH(DW), .PWIDTH(PW), .IDX_W(IDX_W)) bus ();

  mem_depacketizer #(
    .DWIDTH(DW), .PWIDTH(PW), .MY_ADDR(MY_ADDR),
    .DEPTH(DEPTH), .NUM_OUT(NUM_OUT), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus.slave),
    .done(done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] m_q[$];
  int          m_idx  = 0;
  bit          m_done = 1'b0;
  bit          m_ren  = 1'b0;
  int          m_drop = 0;

  function automatic bit m_ready();
    return m_ren && !m_done && (m_q.size() < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_idx = 0; m_done = 1'b0; m_ren = 1'b0; m_drop = 0;
    end else begin
      bit rdy;
      bit vld;
      rdy = m_ready();
      vld = (m_q.size() > 0);
      if (clear) begin
        m_q.delete();
        m_idx = 0; m_done = 1'b0;
      end else begin
        if (vld && bus.out_ready) begin
          void'(m_q.pop_front());
          if (!m_done) begin
            if (m_idx == NUM_OUT - 1) m_done = 1'b1;
            else m_idx++;
          end
        end
        if (bus.pkt_valid && rdy) begin
`ifdef MEM_DEPKT_ADDR_CHECK_EN
          if (bus.pkt_data[45:43] != MY_ADDR) begin
            if (m_drop < 255) m_drop++;
          end else
`endif
          m_q.push_back({bus.pkt_data[46], bus.pkt_data[42:40], bus.pkt_data[7:0]});
        end
      end
      m_ren = 1'b1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("cycle_ctrl",
        {bus.pkt_ready, bus.out_valid, done, bus.out_index, drop_cnt},
        {m_ready(), 1'(m_q.size() > 0), m_done, IDX_W'(m_idx), 8'(m_drop)});
    if (m_q.size() > 0)
      chk("cycle_head", {bus.out_type, bus.out_src, bus.out_data}, m_q[0]);
  end

  // Delivered results as {index, data}.
  logic [12:0] got[$];
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !clear)
      got.push_back({bus.out_index, bus.out_data});
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [46:0] mk(input logic t, input logic [2:0] d, input logic [2:0] s,
                                     input logic [7:0] v);
    return {t, d, s, 32'h4000_FFFF, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Offer one packet; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [46:0] p, input int max);
    bit ok;
    bit r;
    ok = 1'b0;
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = p;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      r = bus.pkt_ready && !clear;
      tick();
      if (r) ok = 1'b1;
    end
    bus.pkt_valid = 1'b0;
    chk("send_accepted", 64'(ok), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs",
        {bus.pkt_ready, bus.out_valid, bus.out_type, bus.out_src, bus.out_data,
         bus.out_index, done, drop_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("ready_low_before_edge", bus.pkt_ready, 1'b0);
    tick();
    chk("ready_after_reset", bus.pkt_ready, 1'b1);

    // Single packet: type 1, dest 110, src 100, data 2A.
    send(mk(1'b1, 3'b110, 3'b100, 8'h2A), 5);
    chk("single_fields",
        {bus.out_valid, bus.out_type, bus.out_src, bus.out_data, bus.out_index},
        {1'b1, 1'b1, 3'd4, 8'h2A, 5'd0});
    chk("model_pin_head", m_q[0], 12'hC2A);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("single_popped", {32'(got.size()), got[0]}, {32'd1, 13'h002A});
    chk("single_empty", bus.out_valid, 1'b0);

    // Backpressure: 4 fill the FIFO, 5th waits.
    pulse_clear();
    got.delete();
    for (int i = 0; i < 4; i++) send(mk(1'b1, 3'b110, 3'(i), 8'(8'h10 + i)), 5);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = mk(1'b1, 3'b110, 3'd4, 8'h14);
    for (int i = 0; i < 3; i++) begin
      chk("full_ready_low", bus.pkt_ready, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    send(mk(1'b1, 3'b110, 3'd4, 8'h14), 10);
    repeat (6) tick();
    bus.out_ready = 1'b0;
    chk("bp_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk("bp_order", got[i], {5'(i), 8'(8'h10 + i)});

    // Completion after 16 results, then restart with clear.
    pulse_clear();
    got.delete();
    bus.out_ready = 1'b1;
    for (int d = 0; d < 16; d++) send(mk(1'b0, 3'b110, 3'b001, 8'(d)), 5);
    repeat (3) tick();
    chk("done_state", {done, bus.out_index, bus.out_valid}, {1'b1, 5'd15, 1'b0});
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = mk(1'b0, 3'b110, 3'b001, 8'h77);
    tick();
    tick();
    chk("done_ready_low", bus.pkt_ready, 1'b0);
    chk("done_count", 64'(got.size()), 64'd16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk("done_order", got[i], {5'(i), 8'(i)});
    pulse_clear();
    chk("after_clear", {done, bus.out_index, bus.out_valid, bus.pkt_ready},
        {1'b0, 5'd0, 1'b0, 1'b1});
    send(mk(1'b0, 3'b110, 3'b001, 8'h77), 5);
    tick();
    chk("pkt17_delivered", got[got.size()-1], {5'd0, 8'h77});
    bus.out_ready = 1'b0;

    // Destination filter.
    pulse_clear();
    got.delete();
    bus.out_ready = 1'b1;
    send(mk(1'b1, 3'b110, 3'd2, 8'h55), 5);
    send(mk(1'b1, 3'b011, 3'd2, 8'h66), 5);
    send(mk(1'b1, 3'b110, 3'd2, 8'h77), 5);
    repeat (3) tick();
`ifdef MEM_DEPKT_ADDR_CHECK_EN
    chk("filter_count", 64'(got.size()), 64'd2);
    chk("filter_drop", drop_cnt, 8'd1);
    chk("filter_data", {got[0][7:0], got[1][7:0]}, 16'h5577);
    for (int i = 0; i < 300; i++) send(mk(1'b1, 3'b011, 3'd2, 8'(i)), 5);
    tick();
    chk("drop_saturate", drop_cnt, 8'd255);
`else
    chk("nofilter_count", 64'(got.size()), 64'd3);
    chk("nofilter_drop", drop_cnt, 8'd0);
    chk("nofilter_data", {got[0][7:0], got[1][7:0], got[2][7:0]}, 24'h556677);
`endif
    bus.out_ready = 1'b0;

    // Reset mid-run with 3 buffered entries.
    pulse_clear();
    got.delete();
    for (int i = 0; i < 4; i++) send(mk(1'b0, 3'b110, 3'd5, 8'(8'hA0 + i)), 5);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pre_reset", {bus.out_valid, bus.out_index, bus.out_data}, {1'b1, 5'd1, 8'hA1});
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.out_valid, bus.out_index, done, bus.pkt_ready}, 8'd0);
    tick();
    #1 rst_n = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b1;
    repeat (2) tick();
    bus.out_ready = 1'b0;
    chk("no_stale", {bus.out_valid, 32'(got.size())}, {1'b0, 32'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
